// File: rtl/nrisc_mc_core.sv
// nrisc_mc_core: multicycle nRisc core with separate req/ack instruction and
// data memory ports. Instructions run through FETCH/DECODE/EXEC/MEM/WB and
// retire one at a time; Retire pulses the cycle after each completion.
module nrisc_mc_core #(
    parameter int               WIDTH    = 8,
    parameter int               NREGS    = 8,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             Clock,
    input  logic             Reset,
    output logic             IMemReq,
    output logic [WIDTH-1:0] IMemAddr,
    input  logic [15:0]      IMemRdata,
    input  logic             IMemAck,
    output logic             DMemReq,
    output logic             DMemWe,
    output logic [WIDTH-1:0] DMemAddr,
    output logic [WIDTH-1:0] DMemWdata,
    input  logic [WIDTH-1:0] DMemRdata,
    input  logic             DMemAck,
    output logic             Retire,
    output logic [WIDTH-1:0] PCOut,
    output logic             Halted
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_SLT  = 4'h4;
    localparam logic [3:0] OP_ADDI = 4'h5;
    localparam logic [3:0] OP_LD   = 4'h6;
    localparam logic [3:0] OP_ST   = 4'h7;
    localparam logic [3:0] OP_BEQ  = 4'h8;
    localparam logic [3:0] OP_JMP  = 4'h9;
    localparam logic [3:0] OP_JR   = 4'hA;
    localparam logic [3:0] OP_HALT = 4'hF;

    logic [2:0]       state;
    logic [WIDTH-1:0] pc;
    logic [15:0]      ir;
    logic [WIDTH-1:0] opa;      // rs value
    logic [WIDTH-1:0] opb;      // rt value
    logic [WIDTH-1:0] opd;      // rd value (BEQ compare, store data)
    logic [WIDTH-1:0] ld_data;
    // r0 is hard-wired to zero, so only r1..r(NREGS-1) are stored
    logic [WIDTH-1:0] regs [NREGS-1:1];

    logic [WIDTH-1:0] rd_a, rd_b, rd_d;
    logic [WIDTH-1:0] imm, pc_inc, pc_exec, agu, alu_res, wr_val;
    logic             alu_wr, wr_en;
    logic [3:0]       op;

    assign op       = ir[15:12];
    assign IMemAddr = pc;
    assign PCOut    = pc;

    // Register-file read ports; r0 and indices beyond NREGS read as zero
    always_comb begin
        rd_a = '0;
        rd_b = '0;
        rd_d = '0;
        for (int i = 1; i < NREGS; i++) begin
            if (ir[7:4] == 4'(i))  rd_a = regs[i];
            if (ir[3:0] == 4'(i))  rd_b = regs[i];
            if (ir[11:8] == 4'(i)) rd_d = regs[i];
        end
    end

    // ALU result, address generation and next-PC selection for EXEC
    always_comb begin
        imm     = {{(WIDTH-4){ir[3]}}, ir[3:0]};
        pc_inc  = pc + WIDTH'(1);
        agu     = opa + imm;
        pc_exec = pc_inc;
        alu_res = '0;
        alu_wr  = 1'b0;
        case (op)
            OP_ADD:  begin alu_res = opa + opb; alu_wr = 1'b1; end
            OP_SUB:  begin alu_res = opa - opb; alu_wr = 1'b1; end
            OP_AND:  begin alu_res = opa & opb; alu_wr = 1'b1; end
            OP_OR:   begin alu_res = opa | opb; alu_wr = 1'b1; end
            OP_SLT:  begin alu_res = (opa < opb) ? WIDTH'(1) : '0; alu_wr = 1'b1; end
            OP_ADDI: begin alu_res = opa + imm; alu_wr = 1'b1; end
            OP_BEQ:  if (opd == opa) pc_exec = pc_inc + imm;
            OP_JMP:  pc_exec = WIDTH'(ir[11:0]);
            OP_JR:   pc_exec = opa;
            default: ;
        endcase
    end

    // Register write happens on the EXEC->FETCH or WB->FETCH edge
    always_comb begin
        wr_en  = 1'b0;
        wr_val = alu_res;
        if (state == S_EXEC && alu_wr) begin
            wr_en = 1'b1;
        end else if (state == S_WB) begin
            wr_en  = 1'b1;
            wr_val = ld_data;
        end
    end

    // Register file: cleared by reset, writes to r0 / out-of-range dropped
    always_ff @(posedge Clock) begin
        if (Reset) begin
            for (int i = 1; i < NREGS; i++) regs[i] <= '0;
        end else if (wr_en) begin
            for (int i = 1; i < NREGS; i++)
                if (ir[11:8] == 4'(i)) regs[i] <= wr_val;
        end
    end

    // Main control FSM: handshakes, PC update and retire/halt flags
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state     <= S_FETCH;
            pc        <= RESET_PC;
            IMemReq   <= 1'b0;
            DMemReq   <= 1'b0;
            DMemWe    <= 1'b0;
            DMemAddr  <= '0;
            DMemWdata <= '0;
            Retire    <= 1'b0;
            Halted    <= 1'b0;
        end else begin
            Retire <= 1'b0;
            case (state)
                S_FETCH: begin
                    // Req is low only on the first fetch after reset
                    if (!IMemReq) begin
                        IMemReq <= 1'b1;
                    end else if (IMemAck) begin
                        ir      <= IMemRdata;
                        IMemReq <= 1'b0;
                        state   <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    opa   <= rd_a;
                    opb   <= rd_b;
                    opd   <= rd_d;
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    if (op == OP_LD || op == OP_ST) begin
                        DMemReq   <= 1'b1;
                        DMemWe    <= (op == OP_ST);
                        DMemAddr  <= agu;
                        DMemWdata <= opd;
                        state     <= S_MEM;
                    end else if (op == OP_HALT) begin
                        Halted <= 1'b1;
                        Retire <= 1'b1;
                        state  <= S_HALT;
                    end else begin
                        pc      <= pc_exec;
                        IMemReq <= 1'b1;
                        Retire  <= 1'b1;
                        state   <= S_FETCH;
                    end
                end
                S_MEM: begin
                    if (DMemAck) begin
                        DMemReq <= 1'b0;
                        DMemWe  <= 1'b0;
                        if (DMemWe) begin
                            pc      <= pc_inc;
                            IMemReq <= 1'b1;
                            Retire  <= 1'b1;
                            state   <= S_FETCH;
                        end else begin
                            ld_data <= DMemRdata;
                            state   <= S_WB;
                        end
                    end
                end
                S_WB: begin
                    pc      <= pc_inc;
                    IMemReq <= 1'b1;
                    Retire  <= 1'b1;
                    state   <= S_FETCH;
                end
                S_HALT: ;
                default: state <= S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_nrisc_mc_core.sv
// Directed testbench for nrisc_mc_core (WIDTH=8, NREGS=4, RESET_PC=0).
module tb_nrisc_mc_core;

    logic        Clock;
    logic        Reset;
    logic        IMemReq;
    logic [7:0]  IMemAddr;
    logic [15:0] IMemRdata;
    logic        IMemAck;
    logic        DMemReq;
    logic        DMemWe;
    logic [7:0]  DMemAddr;
    logic [7:0]  DMemWdata;
    logic [7:0]  DMemRdata;
    logic        DMemAck;
    logic        Retire;
    logic [7:0]  PCOut;
    logic        Halted;

    nrisc_mc_core #(.WIDTH(8), .NREGS(4), .RESET_PC(8'h00)) dut (
        .Clock(Clock), .Reset(Reset),
        .IMemReq(IMemReq), .IMemAddr(IMemAddr), .IMemRdata(IMemRdata), .IMemAck(IMemAck),
        .DMemReq(DMemReq), .DMemWe(DMemWe), .DMemAddr(DMemAddr), .DMemWdata(DMemWdata),
        .DMemRdata(DMemRdata), .DMemAck(DMemAck),
        .Retire(Retire), .PCOut(PCOut), .Halted(Halted)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    logic [15:0] imem [256];
    logic [7:0]  dmem [256];
    assign IMemRdata = imem[IMemAddr];
    assign DMemRdata = dmem[DMemAddr];

    int   i_wait = 0, d_wait = 0, icnt = 0, dcnt = 0;
    logic d_block = 1'b0, dack_force = 1'b0, dack_r = 1'b0;
    assign DMemAck = dack_r | dack_force;

    int        cyc = 0;
    int        retq[$];
    logic [7:0] retpc[$];
    logic [7:0] st_addr[$];
    logic [7:0] st_data[$];
    int        errors = 0, checks = 0;
    int        istab_err = 0, dstab_err = 0;
    logic      prev_ireq = 1'b0, prev_dreq = 1'b0;
    logic [7:0] prev_iaddr = '0, prev_daddr = '0, prev_dwdata = '0;

    // Instruction memory responder: ack after i_wait wait cycles
    always @(negedge Clock) begin
        if (IMemReq) begin
            if (icnt >= i_wait) IMemAck = 1'b1;
            else begin IMemAck = 1'b0; icnt++; end
        end else begin
            IMemAck = 1'b0;
            icnt    = 0;
        end
    end

    // Data memory responder: ack after d_wait wait cycles unless blocked
    always @(negedge Clock) begin
        if (DMemReq && !d_block) begin
            if (dcnt >= d_wait) dack_r = 1'b1;
            else begin dack_r = 1'b0; dcnt++; end
        end else begin
            dack_r = 1'b0;
            if (!DMemReq) dcnt = 0;
        end
    end

    // Store commit and log on completing edges
    always @(posedge Clock) begin
        cyc++;
        if (!Reset && DMemReq && DMemAck && DMemWe) begin
            dmem[DMemAddr] = DMemWdata;
            st_addr.push_back(DMemAddr);
            st_data.push_back(DMemWdata);
        end
    end

    // Retire log and request-stability monitor
    always @(negedge Clock) begin
        if (Retire) begin
            retq.push_back(cyc);
            retpc.push_back(PCOut);
        end
        if (IMemReq && prev_ireq && IMemAddr !== prev_iaddr) istab_err++;
        if (DMemReq && prev_dreq && (DMemAddr !== prev_daddr || DMemWdata !== prev_dwdata)) dstab_err++;
        prev_ireq   = IMemReq;
        prev_iaddr  = IMemAddr;
        prev_dreq   = DMemReq;
        prev_daddr  = DMemAddr;
        prev_dwdata = DMemWdata;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mems();
        for (int i = 0; i < 256; i++) begin
            imem[i] = 16'hB000;
            dmem[i] = 8'h00;
        end
    endtask

    task automatic clear_logs();
        retq.delete();
        retpc.delete();
        st_addr.delete();
        st_data.delete();
        istab_err = 0;
        dstab_err = 0;
    endtask

    // Hold reset for a few cycles, then release on a falling edge
    task automatic pulse_reset();
        Reset = 1'b1;
        repeat (3) @(negedge Clock);
        clear_logs();
        Reset = 1'b0;
    endtask

    task automatic wait_retires(input int n, input string tag);
        int t;
        t = 0;
        while (retq.size() < n && t < 400) begin
            @(negedge Clock);
            t++;
        end
        check(tag, retq.size(), n);
    endtask

    task automatic check_quiet_after_halt(input string tag);
        int reqs;
        reqs = 0;
        repeat (20) begin
            @(negedge Clock);
            if (IMemReq || DMemReq) reqs++;
        end
        check(tag, reqs, 0);
    endtask

    initial begin
        Reset = 1'b1;
        IMemAck = 1'b0;
        clear_mems();

        // ---- Test 1: ADDI/ADDI/ADD, zero-wait, then ST r3 and HALT
        imem[0] = 16'h5105;   // ADDI r1,r0,5
        imem[1] = 16'h520D;   // ADDI r2,r0,-3
        imem[2] = 16'h0312;   // ADD  r3,r1,r2
        imem[3] = 16'h7300;   // ST   r3,[r0+0]
        imem[4] = 16'hF000;   // HALT
        repeat (3) @(negedge Clock);
        check("rst_imemreq", IMemReq, 0);
        check("rst_dmemreq", DMemReq, 0);
        check("rst_dmemwe", DMemWe, 0);
        check("rst_retire", Retire, 0);
        check("rst_halted", Halted, 0);
        check("rst_pc", PCOut, 8'h00);
        check("rst_daddr", DMemAddr, 8'h00);
        check("rst_dwdata", DMemWdata, 8'h00);
        clear_logs();
        Reset = 1'b0;
        @(negedge Clock);
        check("first_imemreq", IMemReq, 1);
        check("first_imemaddr", IMemAddr, 8'h00);
        wait_retires(5, "t1_retires");
        check("t1_gap1", retq[1] - retq[0], 3);
        check("t1_gap2", retq[2] - retq[1], 3);
        check("t1_pc3", retpc[2], 8'h03);
        check("t1_st_gap", retq[3] - retq[2], 4);
        check("t1_halt_gap", retq[4] - retq[3], 3);
        check("t1_st_addr", st_addr[0], 8'h00);
        check("t1_r3", st_data[0], 8'h02);
        check("t1_halted", Halted, 1);

        // ---- Test 2: same program, fetch acks delayed by 2 cycles
        i_wait = 2;
        pulse_reset();
        wait_retires(5, "t2_retires");
        check("t2_gap1", retq[1] - retq[0], 5);
        check("t2_gap2", retq[2] - retq[1], 5);
        check("t2_pc3", retpc[2], 8'h03);
        check("t2_st_gap", retq[3] - retq[2], 6);
        check("t2_r3", st_data[0], 8'h02);
        check("t2_iaddr_stable", istab_err, 0);
        i_wait = 0;

        // ---- Test 3: store then load the same address
        clear_mems();
        dmem[7] = 8'h5A;
        imem[0] = 16'h6107;   // LD r1,[r0+7]   (r1 = 0x5A)
        imem[1] = 16'h7104;   // ST r1,[r0+4]
        imem[2] = 16'h6304;   // LD r3,[r0+4]
        imem[3] = 16'h7305;   // ST r3,[r0+5]
        imem[4] = 16'hF000;   // HALT
        d_wait = 1;
        pulse_reset();
        wait_retires(5, "t3_retires");
        check("t3_st_addr", st_addr[0], 8'h04);
        check("t3_st_data", st_data[0], 8'h5A);
        check("t3_ld_result", st_data[1], 8'h5A);
        check("t3_st2_addr", st_addr[1], 8'h05);
        check("t3_st_gap", retq[1] - retq[0], 5);
        check("t3_ld_gap", retq[2] - retq[1], 6);
        check("t3_daddr_stable", dstab_err, 0);
        d_wait = 0;
        pulse_reset();
        wait_retires(5, "t3z_retires");
        check("t3z_st_gap", retq[1] - retq[0], 4);
        check("t3z_ld_gap", retq[2] - retq[1], 5);
        check("t3z_ld_result", st_data[1], 8'h5A);

        // ---- Test 4: BEQ taken / not taken, JMP 0x0FF and PC wrap
        clear_mems();
        imem[0]    = 16'h5102;  // ADDI r1,r0,2
        imem[1]    = 16'h5302;  // ADDI r3,r0,2
        imem[2]    = 16'h9006;  // JMP 6
        imem[5]    = 16'h533F;  // ADDI r3,r3,-1
        imem[6]    = 16'h831E;  // BEQ r3,r1,-2
        imem[7]    = 16'h90FF;  // JMP 0x0FF
        imem[8'hFF] = 16'h5207; // ADDI r2,r0,7
        pulse_reset();
        wait_retires(8, "t4_retires");
        check("t4_jmp6", retpc[2], 8'h06);
        check("t4_beq_taken", retpc[3], 8'h05);
        check("t4_beq_gap", retq[3] - retq[2], 3);
        check("t4_beq_not_taken", retpc[5], 8'h07);
        check("t4_jmp_ff", retpc[6], 8'hFF);
        check("t4_pc_wrap", retpc[7], 8'h00);

        // ---- Test 5: writes to r0 and r5 (NREGS=4) are discarded
        clear_mems();
        imem[0] = 16'h5103;   // ADDI r1,r0,3
        imem[1] = 16'h5007;   // ADDI r0,r0,7
        imem[2] = 16'h5506;   // ADDI r5,r0,6
        imem[3] = 16'h7001;   // ST r0,[r0+1]
        imem[4] = 16'h7502;   // ST r5,[r0+2]
        imem[5] = 16'h7103;   // ST r1,[r0+3]
        imem[6] = 16'hF000;   // HALT
        pulse_reset();
        wait_retires(7, "t5_retires");
        check("t5_r0", st_data[0], 8'h00);
        check("t5_r5", st_data[1], 8'h00);
        check("t5_r1_intact", st_data[2], 8'h03);
        check("t5_halted", Halted, 1);
        check_quiet_after_halt("t5_no_req_after_halt");
        check("t5_retire_count", retq.size(), 7);

        // ---- Test 6: reset during a withheld load, reset and ack on one edge
        clear_mems();
        dmem[3] = 8'h77;
        imem[0] = 16'h5105;   // ADDI r1,r0,5
        imem[1] = 16'h6103;   // LD r1,[r0+3]
        d_block = 1'b1;
        pulse_reset();
        begin
            int t;
            t = 0;
            while (!DMemReq && t < 100) begin
                @(negedge Clock);
                t++;
            end
        end
        check("t6_dreq_up", DMemReq, 1);
        repeat (2) @(negedge Clock);
        check("t6_dreq_held", DMemReq, 1);
        check("t6_daddr", DMemAddr, 8'h03);
        Reset = 1'b1;
        dack_force = 1'b1;
        @(negedge Clock);
        retq.delete();
        retpc.delete();
        check("t6_dreq_dropped", DMemReq, 0);
        check("t6_pc_reset", PCOut, 8'h00);
        check("t6_ireq_low", IMemReq, 0);
        check("t6_retire_low", Retire, 0);
        imem[0] = 16'h7104;   // ST r1,[r0+4]
        imem[1] = 16'hF000;   // HALT
        Reset = 1'b0;         // late Ack still high for one more cycle
        @(negedge Clock);
        dack_force = 1'b0;
        d_block    = 1'b0;
        check("t6_fetch_restart", IMemReq, 1);
        check("t6_late_ack_ignored", DMemReq, 0);
        wait_retires(2, "t6_retires");
        check("t6_r1_not_written", st_data[0], 8'h00);
        check("t6_st_addr", st_addr[0], 8'h04);
        check("t6_halted", Halted, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
